stitch_vreg_seq: RTL
====================

// Module: stitch_vreg_seq
// PURPOSE
// - Vector operand address sequencer; sits directly upstream of the vector FP register file (VFPR) read/write ports.
// - Accepts one vector instruction: up to three source base registers, one destination base, and vector length vl.
// - Emits one read-address triple per element to the VFPR read ports.
// - Queues each element's destination address in order for the writeback stage.
// PARAMETERS
// - AddrWidth    8  register-address width; matches the VFPR address width
// - VlWidth      8  width of the vector-length field
// - WbFifoDepth  4  destination-address queue depth; must be >= 2
// PORTS
// - clk_i        in   1               clock
// - rst_ni       in   1               asynchronous active-low reset
// - flush_i      in   1               synchronous abort of the current instruction
// - in_valid_i   in   1               instruction valid
// - in_ready_o   out  1               sequencer can accept an instruction
// - in_raddr_i   in   3*AddrWidth     source base registers rs1..rs3
// - in_rmask_i   in   3               source k is used
// - in_waddr_i   in   AddrWidth       destination base register
// - in_wen_i     in   1               instruction writes a destination
// - in_vl_i      in   VlWidth         element count; 0 is legal
// - in_rstride_i in   3*AddrWidth     per-source stride (STITCH_VSEQ_STRIDE_EN only)
// - in_wstride_i in   AddrWidth       destination stride (STITCH_VSEQ_STRIDE_EN only)
// - raddr_o      out  3*AddrWidth     element read addresses to the VFPR
// - rvalid_o     out  3               per-port read valid
// - rready_i     in   3               per-port read ready from the VFPR
// - wb_addr_o    out  AddrWidth       head of the destination queue
// - wb_valid_o   out  1               destination queue non-empty
// - wb_ready_i   in   1               writeback pops the queue head
// - busy_o       out  1               sequencer is in ISSUE, or the queue is non-empty
// BEHAVIOUR
// - Reset values: state=IDLE, in_ready_o=1, rvalid_o=0, raddr_o=0, wb_valid_o=0, busy_o=0, element index=0, latched fields=0.
// - FSM IDLE:
//   - in_ready_o=1.
//   - in_valid_i & vl!=0 -> latch all fields, idx=0, go to ISSUE.
//   - in_valid_i & vl==0 -> accepted, no elements issued, stay in IDLE.
// - FSM ISSUE:
//   - in_ready_o=0.
//   - First element is presented the cycle after acceptance.
//   - raddr_o[k] = base[k] + idx*stride[k], truncated to AddrWidth (wraps modulo 2^AddrWidth).
//   - issue_ok = !(wen & queue_full).
//   - rvalid_o[k] = mask[k] & issue_ok.
//   - fire = issue_ok & &(~mask | rready_i): all-or-nothing across ports.
//   - rvalid_o, raddr_o stay stable until fire. A port that is ready alone does not consume the element.
//   - mask==0: the element fires on issue_ok alone; no read is presented.
//   - On fire: if wen, push waddr_base + idx*wstride into the queue; idx++.
//   - On fire with idx==vl-1: go to IDLE. in_ready_o rises the next cycle (no same-cycle re-accept).
// - Destination queue: FIFO, in element order.
//   - wb_valid_o = !empty; a pop occurs on wb_valid_o & wb_ready_i.
//   - A push and a pop in the same cycle are both legal when the queue is full.
// - flush_i (highest priority):
//   - Next cycle: state=IDLE, idx=0, queue emptied, rvalid_o=0, wb_valid_o=0.
//   - An instruction presented in the flush cycle is not accepted.
// - Reset mid-operation: all state returns to the reset values immediately; no pending pushes survive.
// CONFIGURATION
// - Macro STITCH_VSEQ_STRIDE_EN defined:
//   - Stride ports present; strides are latched with the instruction.
//   - idx*stride is computed by an incremental adder: add stride on each fire, no multiplier.
// - Macro STITCH_VSEQ_STRIDE_EN undefined:
//   - Stride ports absent; all strides are the constant 1, so raddr = base+idx.
// STRUCTURE
// - Package stitch_vseq_pkg:
//   - vseq_instr_t: packed struct of raddr/rmask/waddr/wen/vl and the strides.
//   - vseq_state_e {IDLE, ISSUE}.
// - Sub-module: common_cells fifo_v3 (DEPTH=WbFifoDepth, DATA_WIDTH=AddrWidth).
//   - Used as the destination queue.
//   - flush_i drives its flush_i.
// - Address generation is three identical per-port accumulators plus one for the destination, written in a generate loop.
// TESTING
// - vl=4, rs=(2,10,20), mask=111, rd=30, wen=1, rready=111 ->
//   - raddr triples (2,10,20)..(5,13,23) on 4 consecutive cycles.
//   - queue holds 30,31,32,33.
//   - in_ready_o=1 on cycle 6.
// - Same instruction, rready=101 for 3 cycles then 111 ->
//   - element 0 held stable for 3 cycles; no idx advance until all ports ready.
// - vl=6, wen=1, WbFifoDepth=4, wb_ready=0 ->
//   - 4 elements fire, then rvalid_o=0 stalls.
//   - Asserting wb_ready_i resumes issue; all 6 dests are delivered in order.
// - vl=0, in_valid=1 ->
//   - in_ready_o stays 1, rvalid_o never asserts, busy_o stays 0.
// - rs1=254, vl=4, mask=001 (AddrWidth=8) -> raddr_o[0] = 254,255,0,1 (wrap).
// - flush_i at element 2 of vl=8 with 2 queue entries ->
//   - next cycle IDLE, wb_valid_o=0, busy_o=0, rvalid_o=0.
// - STITCH_VSEQ_STRIDE_EN, stride=(2,0,3), base=(0,5,9), vl=3 ->
//   - triples (0,5,9),(2,5,12),(4,5,15).

Source files
------------

// File: rtl/stitch_vseq_pkg.sv
// Shared types for the vector operand address sequencer.
// Field widths here set the default AddrWidth/VlWidth of stitch_vreg_seq.
package stitch_vseq_pkg;

    localparam int unsigned VSEQ_AW  = 8;
    localparam int unsigned VSEQ_VLW = 8;

    typedef enum logic {
        IDLE,
        ISSUE
    } vseq_state_e;

    typedef struct packed {
        logic [2:0][VSEQ_AW-1:0] raddr;
        logic [2:0]              rmask;
        logic [VSEQ_AW-1:0]      waddr;
        logic                    wen;
        logic [VSEQ_VLW-1:0]     vl;
        logic [2:0][VSEQ_AW-1:0] rstride;
        logic [VSEQ_AW-1:0]      wstride;
    } vseq_instr_t;

endpackage

// File: rtl/stitch_vreg_seq_fifo.sv
// fifo_v3: small in-order queue with synchronous flush.
// A push into a full queue is taken when a pop happens in the same cycle.
module fifo_v3 #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]       rd_q, wr_q;
    logic [PtrW:0]         cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop)
                rd_q <= (rd_q == PtrW'(DEPTH-1)) ? '0 : rd_q + PtrW'(1);
            if (do_push)
                wr_q <= (wr_q == PtrW'(DEPTH-1)) ? '0 : wr_q + PtrW'(1);
            if (do_push && !do_pop)
                cnt_q <= cnt_q + (PtrW+1)'(1);
            else if (do_pop && !do_push)
                cnt_q <= cnt_q - (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stitch_vreg_seq.sv
// stitch_vreg_seq: per-element VFPR read addresses plus an ordered dest queue.
// Define STITCH_VSEQ_STRIDE_EN for per-operand strides; otherwise stride is 1.
module stitch_vreg_seq
    import stitch_vseq_pkg::*;
#(
    parameter int unsigned AddrWidth   = VSEQ_AW,
    parameter int unsigned VlWidth     = VSEQ_VLW,
    parameter int unsigned WbFifoDepth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [3*AddrWidth-1:0] in_raddr_i,
    input  logic [2:0]             in_rmask_i,
    input  logic [AddrWidth-1:0]   in_waddr_i,
    input  logic                   in_wen_i,
    input  logic [VlWidth-1:0]     in_vl_i,
`ifdef STITCH_VSEQ_STRIDE_EN
    input  logic [3*AddrWidth-1:0] in_rstride_i,
    input  logic [AddrWidth-1:0]   in_wstride_i,
`endif
    output logic [3*AddrWidth-1:0] raddr_o,
    output logic [2:0]             rvalid_o,
    input  logic [2:0]             rready_i,
    output logic [AddrWidth-1:0]   wb_addr_o,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic                   busy_o
);

    vseq_state_e                 state_q, state_d;
    vseq_instr_t                 instr_q, instr_d, instr_in;
    logic [VlWidth-1:0]          idx_q, idx_d;
    logic [3:0][AddrWidth-1:0]   addr;
    logic                        q_full, q_empty;
    logic                        accept, issue_ok, fire, last;

    always_comb begin
        instr_in       = '0;
        instr_in.raddr = in_raddr_i;
        instr_in.rmask = in_rmask_i;
        instr_in.waddr = in_waddr_i;
        instr_in.wen   = in_wen_i;
        instr_in.vl    = in_vl_i;
`ifdef STITCH_VSEQ_STRIDE_EN
        instr_in.rstride = in_rstride_i;
        instr_in.wstride = in_wstride_i;
`else
        for (int k = 0; k < 3; k++) instr_in.rstride[k] = AddrWidth'(1);
        instr_in.wstride = AddrWidth'(1);
`endif
    end

    assign in_ready_o = (state_q == IDLE);
    assign accept     = in_ready_o & in_valid_i & ~flush_i;
    // A write element may only issue while the dest queue has room.
    assign issue_ok   = (state_q == ISSUE) & ~(instr_q.wen & q_full);
    assign rvalid_o   = instr_q.rmask & {3{issue_ok}};
    assign fire       = issue_ok & (&(~instr_q.rmask | rready_i));
    assign last       = (idx_q == instr_q.vl - VlWidth'(1));

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        idx_d   = idx_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && in_vl_i != '0) begin
                        state_d = ISSUE;
                        instr_d = instr_in;
                        idx_d   = '0;
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        idx_d = idx_q + VlWidth'(1);
                        if (last) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            instr_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            idx_q   <= idx_d;
        end
    end

    // Ports 0..2 are sources, port 3 is the destination; offset = idx*stride.
    for (genvar k = 0; k < 4; k++) begin : g_acc
        logic [AddrWidth-1:0] base, stride, off_q;
        if (k < 3) begin : g_src
            assign base   = instr_q.raddr[k];
            assign stride = instr_q.rstride[k];
        end else begin : g_dst
            assign base   = instr_q.waddr;
            assign stride = instr_q.wstride;
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                off_q <= '0;
            else if (flush_i || accept)
                off_q <= '0;
            else if (fire)
                off_q <= off_q + stride;
        end
        assign addr[k] = base + off_q;
    end

    assign raddr_o = addr[2:0];

    fifo_v3 #(
        .DEPTH      (WbFifoDepth),
        .DATA_WIDTH (AddrWidth)
    ) u_wb_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fire & instr_q.wen),
        .data_i  (addr[3]),
        .pop_i   (wb_valid_o & wb_ready_i),
        .data_o  (wb_addr_o),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign wb_valid_o = ~q_empty;
    assign busy_o     = (state_q == ISSUE) | ~q_empty;

endmodule
